// File: rtl/pipe_mem_arbiter.sv
// Shared memory-port arbiter for the IF and MEM pipeline stages: data wins, one access in flight.
// Optional ARB_TIMEOUT_EN aborts a stuck access after TIMEOUT request cycles and sets a sticky bus_err.
module pipe_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("pipe_mem_arbiter: TIMEOUT must be in 2..255");
  end

  logic [1:0]    state, state_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic          if_done_nxt, d_done_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          bus_err_nxt;
  logic          expired;
  // The TIMEOUT-th request cycle without an ack ends the access
  assign expired = (cnt == CNT_LIM) && !mem_ack;
`else
  assign bus_err = 1'b0;
`endif

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (clrn) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt       <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_done   <= if_done_nxt;
      d_done    <= d_done_nxt;
`ifdef ARB_TIMEOUT_EN
      cnt       <= cnt_nxt;
      bus_err   <= bus_err_nxt;
`endif
    end
  end

  // Next-state and output logic; a requester whose done is high is not re-granted
  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_done_nxt   = 1'b0;
    d_done_nxt    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt       = cnt;
    bus_err_nxt   = bus_err;
`endif
    case (state)
      IDLE: begin
        if (d_req && !d_done) begin
          state_nxt     = D_BUSY;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt       = '0;
`endif
        end else if (if_req && !if_done) begin
          state_nxt     = IF_BUSY;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt       = '0;
`endif
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          if_rdata_nxt = mem_rdata;
          if_done_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (expired) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          if_rdata_nxt = '0;
          if_done_nxt  = 1'b1;
          bus_err_nxt  = 1'b1;
        end else begin
          cnt_nxt      = cnt + CW'(1);
`endif
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          if (!mem_we) d_rdata_nxt = mem_rdata;
          d_done_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (expired) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          d_rdata_nxt = '0;
          d_done_nxt  = 1'b1;
          bus_err_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + CW'(1);
`endif
        end
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: a per-cycle vector table plus hand sequences
// for mid-transaction reset and the optional timeout.
module tb_pipe_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NV = 22;

  logic          clk = 1'b0;
  logic          clrn;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, if_stall, d_done, d_stall, mem_req, mem_we, bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          if_req, d_req, d_we, ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, rdata;
    logic          e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_if_done, e_d_done, e_if_stall, e_d_stall;
    logic [DW-1:0] e_if_rd, e_d_rd;
  } vec_t;

  vec_t vecs [NV];

  pipe_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A = 32'h0000_0040;
  localparam logic [31:0] D = 32'h0000_0100;
  localparam logic [31:0] S = 32'h0000_0200;
  localparam logic [31:0] W = 32'hDEAD_BEEF;
  localparam logic [31:0] R1 = 32'h2002_0005;
  localparam logic [31:0] R2 = 32'h1111_2222;
  localparam logic [31:0] R3 = 32'h3333_4444;

  initial begin
    // fetch, zero wait
    vecs[0]  = '{1, 0, 0, 0, D, 0, 0,          0, 0, 0, 0, 0, 0, 1, 0, 0,  0};
    vecs[1]  = '{1, 0, 0, 1, D, 0, R1,         1, 0, A, 0, 0, 0, 1, 0, 0,  0};
    vecs[2]  = '{1, 0, 0, 0, D, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, R1, 0};
    vecs[3]  = '{0, 0, 0, 0, D, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, R1, 0};
    // simultaneous load + fetch, 3 wait cycles each
    vecs[4]  = '{1, 1, 0, 0, D, 0, 0,          0, 0, 0, 0, 0, 0, 1, 1, R1, 0};
    vecs[5]  = '{1, 1, 0, 0, D, 0, 0,          1, 0, D, 0, 0, 0, 1, 1, R1, 0};
    vecs[6]  = '{1, 1, 0, 0, D, 0, 0,          1, 0, D, 0, 0, 0, 1, 1, R1, 0};
    vecs[7]  = '{1, 1, 0, 0, D, 0, 0,          1, 0, D, 0, 0, 0, 1, 1, R1, 0};
    vecs[8]  = '{1, 1, 0, 1, D, 0, R2,         1, 0, D, 0, 0, 0, 1, 1, R1, 0};
    vecs[9]  = '{1, 1, 0, 0, D, 0, 0,          0, 0, 0, 0, 0, 1, 1, 0, R1, R2};
    vecs[10] = '{1, 0, 0, 0, D, 0, 0,          1, 0, A, 0, 0, 0, 1, 0, R1, R2};
    vecs[11] = '{1, 0, 0, 0, D, 0, 0,          1, 0, A, 0, 0, 0, 1, 0, R1, R2};
    vecs[12] = '{1, 0, 0, 0, D, 0, 0,          1, 0, A, 0, 0, 0, 1, 0, R1, R2};
    vecs[13] = '{1, 0, 0, 1, D, 0, R3,         1, 0, A, 0, 0, 0, 1, 0, R1, R2};
    vecs[14] = '{1, 0, 0, 0, D, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, R3, R2};
    vecs[15] = '{0, 0, 0, 0, D, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, R3, R2};
    // store, 1 wait cycle; read data on the bus must not reach d_rdata
    vecs[16] = '{0, 1, 1, 0, S, W, 0,          0, 0, 0, 0, 0, 0, 0, 1, R3, R2};
    vecs[17] = '{0, 1, 1, 0, S, W, 0,          1, 1, S, W, 0, 0, 0, 1, R3, R2};
    vecs[18] = '{0, 1, 1, 1, S, W, 32'hFFFF_FFFF, 1, 1, S, W, 0, 0, 0, 1, R3, R2};
    vecs[19] = '{0, 1, 1, 0, S, W, 0,          0, 0, 0, 0, 0, 1, 0, 0, R3, R2};
    // ack while idle is ignored
    vecs[20] = '{0, 0, 0, 1, D, 0, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0, 0, R3, R2};
    vecs[21] = '{0, 0, 0, 0, D, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, R3, R2};

    clrn = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = A; d_addr = D; d_wdata = '0; mem_rdata = '0;
    step(); step();
    clrn = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    step();

    for (int i = 0; i < int'(NV); i++) begin
      if_req = vecs[i].if_req; d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      mem_ack = vecs[i].ack; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d_if_done", i), 32'(if_done), 32'(vecs[i].e_if_done));
      chk($sformatf("v%0d_d_done", i), 32'(d_done), 32'(vecs[i].e_d_done));
      chk($sformatf("v%0d_if_stall", i), 32'(if_stall), 32'(vecs[i].e_if_stall));
      chk($sformatf("v%0d_d_stall", i), 32'(d_stall), 32'(vecs[i].e_d_stall));
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rd);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rd);
      step();
    end
    mem_ack = 0; mem_rdata = '0;

    // reset while D_BUSY without ack
    d_req = 1; d_we = 0; d_addr = 32'h0000_0300;
    step();
    @(negedge clk);
    chk("mid_busy_req", 32'(mem_req), 1);
    step();
    clrn = 1; d_req = 0;
    step();
    clrn = 0;
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(mem_req), 0);
    chk("mid_rst_d_done", 32'(d_done), 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    step();
    @(negedge clk);
    chk("mid_rst_after_req", 32'(mem_req), 0);
    chk("mid_rst_after_done", 32'(d_done), 0);
    step();

`ifdef ARB_TIMEOUT_EN
    // ack in the 4th request cycle wins over the limit
    d_req = 1; d_addr = 32'h0000_0400;
    step(); step(); step(); step();
    mem_ack = 1; mem_rdata = 32'h0000_ABCD;
    @(negedge clk);
    chk("to_ack4_req", 32'(mem_req), 1);
    step();
    mem_ack = 0; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("to_ack4_done", 32'(d_done), 1);
    chk("to_ack4_rdata", d_rdata, 32'h0000_ABCD);
    chk("to_ack4_bus_err", 32'(bus_err), 0);
    step();
    d_req = 0;
    step();
    // no ack at all: abort after 4 request cycles
    begin
      int n;
      logic seen;
      n = 0; seen = 0;
      d_req = 1;
      for (int k = 0; k < 12 && !seen; k++) begin
        @(negedge clk);
        if (mem_req) n++;
        if (d_done) begin
          seen = 1;
          chk("to_rdata_zero", d_rdata, 0);
          chk("to_bus_err_set", 32'(bus_err), 1);
        end
        step();
      end
      d_req = 0;
      chk("to_seen_done", 32'(seen), 1);
      chk("to_req_cycles", 32'(n), 4);
      step();
      @(negedge clk);
      chk("to_bus_err_sticky", 32'(bus_err), 1);
      chk("to_no_regrant", 32'(mem_req), 0);
      step();
    end
`else
    @(negedge clk);
    chk("bus_err_const", 32'(bus_err), 0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Arbiter and sequencer for a single shared memory port used by two pipeline stages of the five-stage CPU. Instruction fetch (IF) and data access (MEM) each present one request at a time; the block grants one of them, drives a request/ack transaction on the memory port, and returns read data with a one-cycle completion pulse. It also generates per-stage stall signals that hold the pipeline until each access completes.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `TIMEOUT`, 16, maximum number of `mem_req` cycles allowed without `mem_ack` (used only with `ARB_TIMEOUT_EN`); legal range 2..255.

Ports:
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `clrn`  in  1  synchronous, active-high reset (1 = reset, sampled on `clk`).
- `if_req`  in  1  fetch request; held until `if_done`.
- `if_addr`  in  AW  fetch address; stable while `if_req` is high.
- `if_rdata`  out  DW  fetched word; registered.
- `if_done`  out  1  one-cycle fetch completion pulse.
- `if_stall`  out  1  `if_req & ~if_done`.
- `d_req`  in  1  data request; held until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data; registered.
- `d_done`  out  1  one-cycle data completion pulse.
- `d_stall`  out  1  `d_req & ~d_done`.
- `mem_req`  out  1  memory request; high until ack or abort.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address (registered at grant).
- `mem_wdata`  out  DW  memory write data (registered at grant).
- `mem_rdata`  in  DW  memory read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  memory completion; one cycle, may arrive in the first `mem_req` cycle.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE: if an eligible `d_req` is present, go to D_BUSY; else if an eligible `if_req` is present, go to IF_BUSY. Data always wins (older instruction). A request is eligible unless its own `*_done` is high in that cycle, which prevents a re-grant of a request that is just completing.
- On grant: `mem_addr`, `mem_wdata` and `mem_we` are captured from the winner (`mem_we` = `d_we` for data, 0 for fetch), and `mem_req` is set to 1.
- BUSY: `mem_req` is held and the captured fields stay constant. When `mem_ack` is high, `mem_req` is cleared, `mem_rdata` is captured into the owner's rdata register (loads and fetches only; stores leave `d_rdata` unchanged), the owner's `*_done` is set to 1 for the next cycle, and the FSM returns to IDLE.
- `mem_ack` in IDLE is ignored.
- A losing requester keeps its stall asserted and is granted in the first eligible IDLE cycle.
- Only one transaction is in flight at a time; there is no pipelining on the memory port.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_done`, `d_done` and `bus_err` are 0; `mem_addr`, `mem_wdata`, `if_rdata` and `d_rdata` are 0.
- Request sampled in cycle t (IDLE): `mem_req` is high from cycle t+1. `mem_ack` arrives in cycle t+1+w, where w ≥ 0 is the number of wait cycles. `*_done` is high in cycle t+2+w and the rdata output is valid from that cycle.
- A zero-wait access therefore has 2 cycles from request to done. Back-to-back access to the same port uses one IDLE cycle, so the next grant is in the done cycle.
- When both requests are present at t: the data access completes first. The fetch is granted in the `d_done` cycle (t+2+w) and its `mem_req` rises at t+3+w.
- Reset mid-transaction: `mem_req` is 0 in the next cycle, no `*_done` is pulsed, and the memory side must discard the access.

## Configuration
- `ARB_TIMEOUT_EN` defined: an 8-bit counter clears on grant and increments each BUSY cycle without `mem_ack`. If the count reaches `TIMEOUT` without an ack (the `TIMEOUT`-th `mem_req` cycle), the block clears `mem_req`, returns to IDLE, pulses the owner's `*_done` next cycle with rdata forced to 0, and sets `bus_err` (sticky until reset). An ack arriving in the same cycle as the limit takes precedence: normal completion, no error.
- `ARB_TIMEOUT_EN` undefined: BUSY waits for `mem_ack` indefinitely, no counter logic is present, and `bus_err` is constant 0.

## Test plan
- Reset, then fetch at 0x0000_0040 with ack in the first `mem_req` cycle and `mem_rdata`=0x2002_0005 -> `mem_req` is high for exactly 1 cycle, `if_done` pulses 2 cycles after `if_req`, `if_rdata`=0x2002_0005, `if_stall` drops in the done cycle.
- `if_req` and `d_req` (load 0x100) raised in the same cycle, with 3 wait cycles each -> data is served first, the fetch `mem_req` rises the cycle after `d_done`, and `if_stall` stays high throughout.
- Store to 0x0000_0200 with wdata 0xDEAD_BEEF -> `mem_we`=1, `mem_wdata`=0xDEAD_BEEF held until ack, `d_done` pulses, `d_rdata` unchanged.
- `clrn` asserted while in D_BUSY with no ack -> next cycle `mem_req`=0, no `d_done`, state IDLE, all outputs at reset values.
- With `ARB_TIMEOUT_EN`, `TIMEOUT`=4, ack never arrives -> `mem_req` is high for 4 cycles, `d_done` pulses with `d_rdata`=0, and `bus_err` stays 1. A repeat with ack in the 4th cycle -> normal completion and `bus_err`=0.
- Ack asserted while IDLE -> no done pulse and no state change.
